// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA constants and loader types: opcodes/functs (common with the
// control decoder), the assembly op-class enum, loader error codes and FSM states.
package mips_isa_pkg;

  // Primary opcodes accepted by the single-cycle control decoder
  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_BEQ   = 6'b000100;
  localparam logic [5:0] OPC_BNE   = 6'b000101;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_LUI   = 6'b001111;
  localparam logic [5:0] OPC_J     = 6'b000010;

  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // Assembly-level op class presented on the loader input; 9..15 are illegal
  typedef enum logic [3:0] {
    OP_RTYPE = 4'd0,
    OP_SLT   = 4'd1,
    OP_BEQ   = 4'd2,
    OP_BNE   = 4'd3,
    OP_LW    = 4'd4,
    OP_SW    = 4'd5,
    OP_ADDI  = 4'd6,
    OP_LUI   = 4'd7,
    OP_J     = 4'd8
  } op_class_e;

  typedef enum logic [1:0] {
    ERR_NONE       = 2'd0,
    ERR_ILLEGAL_OP = 2'd1,
    ERR_IMM_RANGE  = 2'd2,
    ERR_MEM_FULL   = 2'd3
  } err_code_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCEPT,
    ST_ENCODE,
    ST_WRITE,
    ST_DONE
  } load_state_e;

  // One captured program entry
  typedef struct packed {
    logic [3:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm;
    logic        last;
  } entry_t;

  // True when a 32-bit two's-complement value is representable in 16 bits:
  // the upper 17 bits must all equal the sign bit.
  function automatic logic fits_simm16(input logic [31:0] value);
    return (&value[31:15]) | ~(|value[31:15]);
  endfunction

endpackage

// File: rtl/instr_field_encoder.sv
// Combinational encoder: assembly fields -> 32-bit MIPS word plus
// illegal-op and immediate-range flags.
module instr_field_encoder
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [5:0]  funct,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_err
);

  // Select the instruction format and check the immediate for this op class
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    word      = '0;
    illegal   = 1'b0;
    range_err = 1'b0;
    case (op)
      OP_RTYPE: word = {OPC_RTYPE, rs, rt, rd, 5'd0, funct};
      OP_SLT:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FUNCT_SLT};
      OP_BEQ: begin
        word      = {OPC_BEQ, rs, rt, imm[15:0]};
        range_err = ~fits_simm16(imm);
      end
      OP_BNE: begin
        word      = {OPC_BNE, rs, rt, imm[15:0]};
        range_err = ~fits_simm16(imm);
      end
      OP_LW: begin
        word      = {OPC_LW, rs, rt, imm[15:0]};
        range_err = ~fits_simm16(imm);
      end
      OP_SW: begin
        word      = {OPC_SW, rs, rt, imm[15:0]};
        range_err = ~fits_simm16(imm);
      end
      OP_ADDI: begin
        word      = {OPC_ADDI, rs, rt, imm[15:0]};
        range_err = ~fits_simm16(imm);
      end
      OP_LUI: begin
        // LUI has no source register; rs is always encoded as zero
        word      = {OPC_LUI, 5'd0, rt, imm[15:0]};
        range_err = |imm[31:16];
      end
      OP_J: begin
        word      = {OPC_J, imm[25:0]};
        range_err = |imm[31:26];
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts assembly entries over valid/ready, encodes each into
// a MIPS word and writes it to sequential instruction-memory addresses.
module instr_encoder_loader
  import mips_isa_pkg::*;
#(
  parameter int          ADDR_W    = 8,
  parameter int unsigned BASE_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W-1:0] BASE      = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  load_state_e state, state_n;
  entry_t      entry_q;
  err_code_e   err_code_q;

  logic [31:0] enc_word;
  logic        enc_illegal;
  logic        enc_range_err;
  logic        reject;
  logic        at_last_addr;

  instr_field_encoder u_encoder (
    .op        (entry_q.op),
    .rs        (entry_q.rs),
    .rt        (entry_q.rt),
    .rd        (entry_q.rd),
    .funct     (entry_q.funct),
    .imm       (entry_q.imm),
    .word      (enc_word),
    .illegal   (enc_illegal),
    .range_err (enc_range_err)
  );

  assign reject       = enc_illegal | enc_range_err;
  assign at_last_addr = (mem_addr == LAST_ADDR);
  assign err_code     = err_code_q;

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  // Next-state logic and state-decoded handshake/status outputs
  always_comb begin
    state_n  = state;
    in_ready = 1'b0;
    mem_we   = 1'b0;
    busy     = 1'b1;
    done     = 1'b0;
    case (state)
      ST_IDLE: begin
        busy = 1'b0;
        if (start) state_n = ST_ACCEPT;
      end
      ST_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid) state_n = ST_ENCODE;
      end
      ST_ENCODE: begin
        if (reject) state_n = entry_q.last ? ST_DONE : ST_ACCEPT;
        else        state_n = ST_WRITE;
      end
      ST_WRITE: begin
        mem_we = 1'b1;
        // Finishing the top word without a last entry leaves nowhere to write
        if (entry_q.last || at_last_addr) state_n = ST_DONE;
        else                              state_n = ST_ACCEPT;
      end
      ST_DONE: begin
        busy = 1'b0;
        done = 1'b1;
        if (start) state_n = ST_ACCEPT;
      end
      default: begin
        busy    = 1'b0;
        state_n = ST_IDLE;
      end
    endcase
  end

  // Entry capture, word register, address/count and sticky error tracking
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      entry_q    <= '0;
      mem_addr   <= BASE;
      mem_wdata  <= '0;
      count      <= '0;
      err        <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            mem_addr   <= BASE;
            count      <= '0;
            err        <= 1'b0;
            err_code_q <= ERR_NONE;
          end
        end
        ST_ACCEPT: begin
          if (in_valid) begin
            entry_q <= '{op: in_op, rs: in_rs, rt: in_rt, rd: in_rd,
                         funct: in_funct, imm: in_imm, last: in_last};
          end
        end
        ST_ENCODE: begin
          if (reject) begin
            err <= 1'b1;
            if (err_code_q == ERR_NONE)
              err_code_q <= enc_illegal ? ERR_ILLEGAL_OP : ERR_IMM_RANGE;
          end else begin
            mem_wdata <= enc_word;
          end
        end
        ST_WRITE: begin
          mem_addr <= mem_addr + 1'b1;
          count    <= count + 1'b1;
          if (!entry_q.last && at_last_addr) begin
            err <= 1'b1;
            if (err_code_q == ERR_NONE) err_code_q <= ERR_MEM_FULL;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Self-checking bench: a full-size loader (ADDR_W=8) and a tiny one (ADDR_W=2)
// share one stimulus bus; a reference model predicts writes and status.
module tb_instr_encoder_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_op = '0;
  logic [4:0]  in_rs = '0, in_rt = '0, in_rd = '0;
  logic [5:0]  in_funct = '0;
  logic [31:0] in_imm = '0;
  logic        in_last = 1'b0;
  logic        sel = 1'b0;   // 0: large instance, 1: small instance

  logic        a_ready, a_we, a_busy, a_done, a_err;
  logic [7:0]  a_addr;
  logic [31:0] a_wdata;
  logic [1:0]  a_code;
  logic [8:0]  a_count;

  logic        b_ready, b_we, b_busy, b_done, b_err;
  logic [1:0]  b_addr;
  logic [31:0] b_wdata;
  logic [1:0]  b_code;
  logic [2:0]  b_count;

  instr_encoder_loader #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start & ~sel), .in_valid(in_valid & ~sel),
    .in_ready(a_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
    .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata), .busy(a_busy),
    .done(a_done), .err(a_err), .err_code(a_code), .count(a_count)
  );

  instr_encoder_loader #(.ADDR_W(2), .BASE_ADDR(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start & sel), .in_valid(in_valid & sel),
    .in_ready(b_ready), .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_funct(in_funct), .in_imm(in_imm), .in_last(in_last),
    .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata), .busy(b_busy),
    .done(b_done), .err(b_err), .err_code(b_code), .count(b_count)
  );

  // Outputs of the instance currently under test
  logic        o_ready, o_we, o_busy, o_done, o_err;
  logic [7:0]  o_addr;
  logic [31:0] o_wdata;
  logic [1:0]  o_code;
  logic [8:0]  o_count;
  assign o_ready = sel ? b_ready : a_ready;
  assign o_we    = sel ? b_we    : a_we;
  assign o_busy  = sel ? b_busy  : a_busy;
  assign o_done  = sel ? b_done  : a_done;
  assign o_err   = sel ? b_err   : a_err;
  assign o_addr  = sel ? {6'd0, b_addr}  : a_addr;
  assign o_wdata = sel ? b_wdata : a_wdata;
  assign o_code  = sel ? b_code  : a_code;
  assign o_count = sel ? {6'd0, b_count} : a_count;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    int          addr;
    logic [31:0] word;
  } wr_t;

  wr_t         exp_q[$];
  int          md_addr, md_count, md_code, md_aw;
  bit          md_err, md_done;
  logic [31:0] last_wdata = '0;

  // kind: 0 encodable, 1 illegal op, 2 immediate out of range
  function automatic void model_encode(input int op, input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] funct,
                                       input logic [31:0] imm, output int kind,
                                       output logic [31:0] word);
    longint s;
    longint u;
    logic [5:0] opc;
    s = longint'($signed(imm));
    u = longint'(imm);
    kind = 0;
    word = '0;
    case (op)
      0: word = {6'h00, rs, rt, rd, 5'd0, funct};
      1: word = {6'h00, rs, rt, rd, 5'd0, 6'h2A};
      2, 3, 4, 5, 6: begin
        opc = (op == 2) ? 6'h04 : (op == 3) ? 6'h05 : (op == 4) ? 6'h23 :
              (op == 5) ? 6'h2B : 6'h08;
        if (s < -32768 || s > 32767) kind = 2;
        word = {opc, rs, rt, imm[15:0]};
      end
      7: begin
        if (u > 65535) kind = 2;
        word = {6'h0F, 5'd0, rt, imm[15:0]};
      end
      8: begin
        if (u >= 64'd67108864) kind = 2;
        word = {6'h02, imm[25:0]};
      end
      default: kind = 1;
    endcase
  endfunction

  task automatic model_clear();
    md_addr = 0; md_count = 0; md_code = 0; md_err = 0; md_done = 0;
    exp_q.delete();
  endtask

  // Compare process: every write strobe must match the next predicted write
  always @(negedge clk) begin
    wr_t e;
    if (o_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(o_we), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("write_cycle", 32'(cyc), 32'(e.cyc));
        check("write_addr", 32'(o_addr), 32'(e.addr));
        check("write_data", o_wdata, e.word);
      end
      last_wdata = o_wdata;
    end
    if (sel ? a_we : b_we) check("idle_instance_write", 32'(sel ? a_we : b_we), 32'd0);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs();
    check("rst_in_ready", 32'(o_ready), 32'd0);
    check("rst_mem_we", 32'(o_we), 32'd0);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_done", 32'(o_done), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    check("rst_err_code", 32'(o_code), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_mem_addr", 32'(o_addr), 32'd0);
    check("rst_mem_wdata", o_wdata, 32'd0);
  endtask

  task automatic start_prog(input bit s);
    sel = s;
    start = 1'b1;
    tick();
    start = 1'b0;
    model_clear();
    md_aw = s ? 2 : 8;
  endtask

  task automatic send(input int op, input int rs, input int rt, input int rd, input int funct,
                      input logic [31:0] imm, input bit last, input bit pin,
                      input logic [31:0] lit);
    int          kind;
    int          hs;
    bit          got;
    bit          full;
    logic [31:0] w;
    in_op = 4'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_funct = 6'(funct); in_imm = imm; in_last = last;
    in_valid = 1'b1;
    if (md_done) begin
      // Finished program: the entry must never be taken
      repeat (6) begin
        check("no_accept_when_done", 32'(o_ready), 32'd0);
        tick();
      end
      in_valid = 1'b0;
      return;
    end
    got = 0;
    hs = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (o_ready) begin
        hs = cyc;
        got = 1;
      end
      tick();
    end
    in_valid = 1'b0;
    check("handshake_seen", 32'(got), 32'd1);
    if (!got) return;
    // Scramble the bus: captured fields must be the ones encoded
    in_op = 4'($urandom); in_imm = $urandom; in_rs = 5'($urandom); in_last = 1'($urandom);

    model_encode(op, 5'(rs), 5'(rt), 5'(rd), 6'(funct), imm, kind, w);
    if (kind == 0) begin
      exp_q.push_back('{hs + 2, md_addr, w});
      full = (md_addr == (1 << md_aw) - 1);
      md_addr = (md_addr + 1) % (1 << md_aw);
      md_count++;
      if (last) md_done = 1;
      else if (full) begin
        md_done = 1;
        md_err = 1;
        if (md_code == 0) md_code = 3;
      end
    end else begin
      md_err = 1;
      if (md_code == 0) md_code = kind;
      if (last) md_done = 1;
    end

    for (int i = 0; i < 10 && !(o_ready || o_done); i++) tick();
    check("settled", 32'(o_ready | o_done), 32'd1);
    check("count", 32'(o_count), 32'(md_count));
    check("err", 32'(o_err), 32'(md_err));
    check("err_code", 32'(o_code), 32'(md_code));
    check("done", 32'(o_done), 32'(md_done));
    check("busy", 32'(o_busy), 32'(!md_done));
    check("write_outstanding", 32'(exp_q.size()), 32'd0);
    if (pin && kind == 0) check("literal_word", last_wdata, lit);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed program ----------------
  initial begin
    bit got;
    rst_n = 1'b0;
    sel = 1'b0;
    tick(); tick();
    model_clear();
    check_zero_outputs();
    rst_n = 1'b1;
    tick();
    check("idle_no_ready", 32'(o_ready), 32'd0);

    // Program 1: I-type/LUI/J encodings and simm16 boundaries
    start_prog(0);
    send(6, 0, 8, 0, 0, 32'd5, 0, 1, 32'h20080005);
    start = 1'b1; tick(); start = 1'b0;           // start while accepting: ignored
    send(7, 7, 1, 0, 0, 32'h00001234, 0, 1, 32'h3C011234);
    send(8, 0, 0, 0, 0, 32'h00000040, 0, 1, 32'h08000040);
    send(6, 1, 2, 0, 0, 32'hFFFF8000, 0, 1, 32'h20228000);
    send(6, 0, 3, 0, 0, 32'h00007FFF, 0, 1, 32'h20037FFF);
    send(5, 29, 31, 0, 0, 32'd4, 1, 1, 32'hAFBF0004);

    // Program 2: R-type then branch with negative offset, last
    start_prog(0);
    send(0, 9, 10, 8, 6'h20, 32'd0, 0, 1, 32'h012A4020);
    send(2, 8, 0, 0, 0, 32'hFFFFFFFF, 1, 1, 32'h1100FFFF);

    // Program 3: rejections; first error code sticks
    start_prog(0);
    send(6, 0, 8, 0, 0, 32'd32768, 0, 0, 32'd0);
    send(6, 0, 8, 0, 0, 32'd5, 0, 1, 32'h20080005);
    send(9, 1, 1, 1, 0, 32'd0, 0, 0, 32'd0);
    send(7, 0, 1, 0, 0, 32'h00010000, 0, 0, 32'd0);
    send(8, 0, 0, 0, 0, 32'h04000000, 0, 0, 32'd0);
    send(6, 0, 1, 0, 0, 32'hFFFF7FFF, 0, 0, 32'd0);
    send(1, 4, 5, 6, 0, 32'd0, 0, 1, 32'h0085302A);
    send(3, 3, 4, 0, 0, 32'd2, 0, 1, 32'h14640002);
    send(4, 29, 2, 0, 0, 32'hFFFFFFFC, 1, 1, 32'h8FA2FFFC);

    // Program 4: illegal op marked last ends the program with nothing written
    start_prog(0);
    send(12, 0, 0, 0, 0, 32'd0, 1, 0, 32'd0);
    send(6, 0, 8, 0, 0, 32'd5, 0, 0, 32'd0);

    // Reset while an entry is in ENCODE: the word must never be written
    start_prog(0);
    in_op = 4'd6; in_rs = 5'd0; in_rt = 5'd8; in_imm = 32'd5; in_last = 1'b0;
    in_valid = 1'b1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (o_ready) got = 1;
      tick();
    end
    in_valid = 1'b0;
    check("abort_handshake", 32'(got), 32'd1);
    rst_n = 1'b0;
    tick();
    model_clear();
    check_zero_outputs();
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    start_prog(0);
    send(6, 0, 8, 0, 0, 32'd5, 0, 1, 32'h20080005);

    // start and reset together: reset wins, loader stays idle
    start = 1'b1; rst_n = 1'b0;
    tick();
    start = 1'b0; rst_n = 1'b1;
    model_clear();
    tick();
    check("reset_wins_busy", 32'(o_busy), 32'd0);
    check("reset_wins_ready", 32'(o_ready), 32'd0);

    // Small instance: four writes fill memory, fifth entry never accepted
    start_prog(1);
    for (int i = 0; i < 5; i++)
      send(6, 0, i + 1, 0, 0, 32'(i), 0, 1, 32'h20000000 | 32'((i + 1) << 16) | 32'(i));
    check("full_count", 32'(o_count), 32'd4);
    check("full_err_code", 32'(o_code), 32'd3);
    sel = 1'b0;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
